wb_cpu_mailbox: RTL

WB_CPU_MAILBOX -- requirements
Module: wb_cpu_mailbox

---
 rtl/wb_cpu_mailbox_pkg.sv | 35 +++
 rtl/wb_cpu_mailbox_sync.sv | 43 ++++
 rtl/wb_cpu_mailbox.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/wb_cpu_mailbox_pkg.sv
// Shared constants and types for the host-to-CPU mailbox.
// Holds register offsets, the host region bit and STATUS field layout.
package wb_cpu_mailbox_pkg;

    localparam logic [1:0] REG_STATUS = 2'd0;
    localparam logic [1:0] REG_WCOUNT = 2'd1;

    localparam int HOST_SEL_BIT = 12;
    localparam int HOST_ADR_W   = 13;

    localparam int ST_PENDING_BIT = 0;
    localparam int ST_DB_LSB      = 8;
    localparam int ST_DB_W        = 8;

    typedef struct packed {
        logic [HOST_ADR_W-1:0] adr;
        logic [7:0]            dat;
    } host_wr_t;

    function automatic logic [3:0] lane_mask(input logic [1:0] lane);
        return 4'b0001 << lane;
    endfunction

    function automatic logic [31:0] status_word(
        input logic [7:0] db,
        input logic       pend
    );
        logic [31:0] w;
        w = '0;
        w[ST_DB_LSB +: ST_DB_W] = db;
        w[ST_PENDING_BIT]       = pend;
        return w;
    endfunction

endpackage

// File: rtl/wb_cpu_mailbox_sync.sv
// Two-flop synchronizer with rising-edge detect for an idle-high strobe.
// Edges are suppressed until a genuine high sample has been seen after reset.
module mailbox_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise
);

    logic       s1;
    logic       s2;
    logic       s3;
    logic [1:0] vld;
    logic       armed;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1  <= 1'b1;
            s2  <= 1'b1;
            s3  <= 1'b1;
            vld <= 2'b00;
        end else begin
            s1  <= d;
            s2  <= s1;
            s3  <= s2;
            vld <= {vld[0], 1'b1};
        end
    end

    // A strobe held low across reset must first be seen high to re-arm.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            armed <= 1'b0;
        end else if (vld[1] && s2) begin
            armed <= 1'b1;
        end
    end

    assign q    = s2;
    assign rise = s2 & ~s3 & armed;

endmodule

// File: rtl/wb_cpu_mailbox.sv
// Host SRAM-bus to Wishbone mailbox: byte RAM, doorbell and write counter.
// Define MAILBOX_IRQ_EN to enable PENDING, irq and the STATUS clear.
module wb_cpu_mailbox
    import wb_cpu_mailbox_pkg::*;
#(
    parameter int mem_adr_w = 11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_stb_i,
    input  logic        wb_cyc_i,
    input  logic        wb_we_i,
    output logic        wb_ack_o,
    input  logic [12:0] addr,
    input  logic [7:0]  sram_data,
    input  logic        nwe,
    input  logic        noe,
    input  logic        ncs,
    output logic        irq
);

    localparam int WA    = mem_adr_w - 2;
    localparam int WORDS = 1 << WA;

    logic ncs_q;
    logic ncs_rise;
    logic nwe_q;
    logic nwe_rise;
    logic noe_q;
    logic noe_rise;

    mailbox_sync u_sync_ncs (
        .clk  (clk),
        .rst  (rst),
        .d    (ncs),
        .q    (ncs_q),
        .rise (ncs_rise)
    );

    mailbox_sync u_sync_nwe (
        .clk  (clk),
        .rst  (rst),
        .d    (nwe),
        .q    (nwe_q),
        .rise (nwe_rise)
    );

    mailbox_sync u_sync_noe (
        .clk  (clk),
        .rst  (rst),
        .d    (noe),
        .q    (noe_q),
        .rise (noe_rise)
    );

    // Host bus is stable while the synchronized strobes are low.
    host_wr_t host_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            host_q <= '0;
        end else if (!nwe_q && !ncs_q) begin
            host_q.adr <= addr;
            host_q.dat <= sram_data;
        end
    end

    logic host_commit;
    logic host_db_we;
    logic host_ram_we;

    assign host_commit = nwe_rise & ~ncs_q;
    assign host_db_we  = host_commit & host_q.adr[HOST_SEL_BIT];
    assign host_ram_we = host_commit & ~host_q.adr[HOST_SEL_BIT];

    logic       wb_req;
    logic       wb_ram_sel;
    logic       wb_go;
    logic [1:0] wb_reg;

    assign wb_req     = wb_stb_i & wb_cyc_i & ~wb_ack_o;
    assign wb_ram_sel = ~wb_adr_i[mem_adr_w];
    assign wb_go      = wb_req & ~(wb_ram_sel & host_ram_we);
    assign wb_reg     = wb_adr_i[3:2];

    logic [WA-1:0] ram_addr;
    logic [3:0]    ram_be;
    logic [31:0]   ram_wdata;
    logic [31:0]   ram_rdata;
    logic [31:0]   mem [WORDS];

    always_comb begin
        ram_addr  = wb_adr_i[mem_adr_w-1:2];
        ram_be    = '0;
        ram_wdata = wb_dat_i;
        if (host_ram_we) begin
            ram_addr  = host_q.adr[mem_adr_w-1:2];
            ram_be    = lane_mask(host_q.adr[1:0]);
            ram_wdata = {4{host_q.dat}};
        end else if (wb_go && wb_ram_sel && wb_we_i) begin
            ram_be = wb_sel_i;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (ram_be[i]) begin
                mem[ram_addr][i*8 +: 8] <= ram_wdata[i*8 +: 8];
            end
        end
    end

    assign ram_rdata = mem[ram_addr];

    logic [7:0]  doorbell;
    logic [15:0] wcount;
    logic        pending;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            doorbell <= '0;
            wcount   <= '0;
        end else begin
            if (host_db_we) begin
                doorbell <= host_q.dat;
            end
            if (host_commit) begin
                wcount <= wcount + 16'd1;
            end
        end
    end

`ifdef MAILBOX_IRQ_EN
    logic wb_clr;

    assign wb_clr = wb_go & ~wb_ram_sel & wb_we_i
                  & (wb_reg == REG_STATUS)
                  & wb_sel_i[ST_PENDING_BIT]
                  & wb_dat_i[ST_PENDING_BIT];

    // A doorbell arriving with a clear wins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending <= 1'b0;
            irq     <= 1'b0;
        end else begin
            if (host_db_we) begin
                pending <= 1'b1;
            end else if (wb_clr) begin
                pending <= 1'b0;
            end
            irq <= pending;
        end
    end
`else
    assign pending = 1'b0;
    assign irq     = 1'b0;
`endif

    logic [31:0] reg_rdata;

    always_comb begin
        reg_rdata = '0;
        unique case (1'b1)
            wb_reg == REG_STATUS: reg_rdata = status_word(doorbell, pending);
            wb_reg == REG_WCOUNT: reg_rdata = {16'b0, wcount};
            default:              reg_rdata = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_ack_o <= 1'b0;
            wb_dat_o <= '0;
        end else begin
            wb_ack_o <= wb_go;
            if (wb_go && !wb_we_i) begin
                wb_dat_o <= wb_ram_sel ? ram_rdata : reg_rdata;
            end
        end
    end

    logic unused_bits;
    assign unused_bits = ^{wb_adr_i, host_q.adr, noe_q, noe_rise, ncs_rise};

endmodule
